timer_pulse_gen_multi: RTL and testbench

Multi-channel, parametrised timed-pulse generator: each of `NUM_CHANNELS` independent channels divides `clk` by a programmable period and emits one-cycle pulses, either periodically or as a single shot. It is the next-generation replacement for the single-channel fixed-8-bit unit pulse generator in the timer subsystem. It sits between the CPU-side timer register file, which drives the config write port, and the timer/counter cores, which consume `pulse`.

---
 rtl/timer_pulse_pkg.sv | 19 +
 rtl/timer_pulse_channel.sv | 84 ++++++++
 rtl/timer_pulse_gen_multi.sv | 47 ++++
 tb/tb_timer_pulse_gen_multi.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/timer_pulse_pkg.sv
// timer_pulse_pkg: shared types and helpers for the multi-channel timed-pulse generator.
package timer_pulse_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } chan_state_t;

    typedef enum logic {
        PERIODIC,
        ONE_SHOT
    } pulse_mode_t;

    // Channel-select width; a single channel still gets a one-bit select.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/timer_pulse_channel.sv
// timer_pulse_channel: one channel with period/mode registers, counter and IDLE/RUN FSM.
module timer_pulse_channel
    import timer_pulse_pkg::*;
#(
    parameter int CNT_WIDTH      = 16,
    parameter int DEFAULT_PERIOD = 100,
    parameter int DEFAULT_MODE   = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr,
    input  logic [CNT_WIDTH-1:0] wr_period,
    input  logic                 wr_mode,
    input  logic                 wr_start,
    input  logic                 enable,
    output logic                 pulse,
    output logic                 running,
    output logic                 done
);

    localparam pulse_mode_t RST_MODE  = (DEFAULT_MODE != 0) ? ONE_SHOT : PERIODIC;
    localparam chan_state_t RST_STATE = (RST_MODE == PERIODIC) ? RUN : IDLE;

    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] cnt_inc;
    pulse_mode_t          mode_q, mode_d;
    chan_state_t          state_q, state_d;
    logic                 pulse_q, pulse_d;
    logic                 done_q, done_d;

    assign cnt_inc = cnt_q + CNT_WIDTH'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_q <= CNT_WIDTH'(DEFAULT_PERIOD);
            mode_q   <= RST_MODE;
            state_q  <= RST_STATE;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            period_q <= period_d;
            mode_q   <= mode_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
            done_q   <= done_d;
        end
    end

    // A write always wins over a terminal count landing on the same edge.
    always_comb begin
        period_d = period_q;
        mode_d   = mode_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        pulse_d  = 1'b0;
        done_d   = done_q;
        if (wr) begin
            period_d = wr_period;
            mode_d   = pulse_mode_t'(wr_mode);
            state_d  = wr_start ? RUN : IDLE;
            cnt_d    = '0;
            done_d   = 1'b0;
        end else if (state_q == RUN && enable && period_q != '0) begin
            if (cnt_inc == period_q) begin
                cnt_d   = '0;
                pulse_d = 1'b1;
                if (mode_q == ONE_SHOT) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    assign pulse   = pulse_q;
    assign running = (state_q == RUN);
    assign done    = done_q;

endmodule

// File: rtl/timer_pulse_gen_multi.sv
// timer_pulse_gen_multi: NUM_CHANNELS independent periodic/one-shot pulse channels
// sharing a single config write port.
module timer_pulse_gen_multi
    import timer_pulse_pkg::*;
#(
    parameter int NUM_CHANNELS   = 4,
    parameter int CNT_WIDTH      = 16,
    parameter int DEFAULT_PERIOD = 100,
    parameter int DEFAULT_MODE   = 0
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 cfg_we,
    input  logic [ch_width(NUM_CHANNELS)-1:0]    cfg_ch,
    input  logic [CNT_WIDTH-1:0]                 cfg_period,
    input  logic                                 cfg_mode,
    input  logic                                 cfg_start,
    input  logic [NUM_CHANNELS-1:0]              enable,
    output logic [NUM_CHANNELS-1:0]              pulse,
    output logic [NUM_CHANNELS-1:0]              running,
    output logic [NUM_CHANNELS-1:0]              done
);

    localparam int CH_W = ch_width(NUM_CHANNELS);

    // Out-of-range selects match no channel, so such writes are dropped.
    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        localparam logic [CH_W-1:0] IDX = CH_W'(i);
        timer_pulse_channel #(
            .CNT_WIDTH      (CNT_WIDTH),
            .DEFAULT_PERIOD (DEFAULT_PERIOD),
            .DEFAULT_MODE   (DEFAULT_MODE)
        ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .wr        (cfg_we && cfg_ch == IDX),
            .wr_period (cfg_period),
            .wr_mode   (cfg_mode),
            .wr_start  (cfg_start),
            .enable    (enable[i]),
            .pulse     (pulse[i]),
            .running   (running[i]),
            .done      (done[i])
        );
    end

endmodule

// File: tb/tb_timer_pulse_gen_multi.sv
// tb_timer_pulse_gen_multi: random and directed stimulus checked against a countdown model.
module tb_timer_pulse_gen_multi;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_period;
    logic        cfg_mode, cfg_start;
    logic [3:0]  enable, pulse, running, done;

    logic        cfg_we3;
    logic [1:0]  cfg_ch3 = 2'd3;
    logic [7:0]  cfg_period3 = 8'd1;
    logic [2:0]  enable3 = 3'b111;
    logic [2:0]  pulse3, running3, done3;

    always #5 clk = ~clk;

    timer_pulse_gen_multi dut (
        .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_mode(cfg_mode), .cfg_start(cfg_start),
        .enable(enable), .pulse(pulse), .running(running), .done(done)
    );

    timer_pulse_gen_multi #(.NUM_CHANNELS(3), .CNT_WIDTH(8), .DEFAULT_PERIOD(7)) dut3 (
        .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we3), .cfg_ch(cfg_ch3),
        .cfg_period(cfg_period3), .cfg_mode(1'b1), .cfg_start(1'b1),
        .enable(enable3), .pulse(pulse3), .running(running3), .done(done3)
    );

    int m_per[4], m_rem[4], pcnt[4];
    bit m_mode[4], m_run[4], m_pulse[4], m_done[4];
    int cyc, n_chk, n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [3:0] m_vec(input int which);
        logic [3:0] v;
        for (int k = 0; k < 4; k++)
            v[k] = (which == 0) ? m_pulse[k] : (which == 1) ? m_run[k] : m_done[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_per[k] = 100; m_rem[k] = 100; m_mode[k] = 0;
            m_run[k] = 1; m_pulse[k] = 0; m_done[k] = 0; pcnt[k] = 0;
        end
        cyc = 0;
    endtask

    task automatic step(input bit we, input int ch, input int per, input bit md,
                        input bit st, input logic [3:0] en);
        @(negedge clk);
        check("pulse", 32'(pulse), 32'(m_vec(0)));
        check("running", 32'(running), 32'(m_vec(1)));
        check("done", 32'(done), 32'(m_vec(2)));
        check("pulse_n3", 32'(pulse3), (cyc > 0 && cyc % 7 == 0) ? 32'h7 : 32'h0);
        for (int k = 0; k < 4; k++) pcnt[k] += int'(pulse[k]);
        cfg_we = we; cfg_ch = 2'(ch); cfg_period = 16'(per);
        cfg_mode = md; cfg_start = st; enable = en;
        cfg_we3 = ($urandom % 3 == 0);
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (we && ch == k) begin
                m_per[k] = per; m_rem[k] = per; m_mode[k] = md;
                m_run[k] = st; m_pulse[k] = 0; m_done[k] = 0;
            end else if (m_run[k] && en[k] && m_per[k] != 0) begin
                m_rem[k]--;
                m_pulse[k] = (m_rem[k] == 0);
                if (m_rem[k] == 0) begin
                    m_rem[k] = m_per[k];
                    if (m_mode[k]) begin
                        m_run[k] = 0;
                        m_done[k] = 1;
                    end
                end
            end else begin
                m_pulse[k] = 0;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 4'hF);
    endtask

    task automatic clr_pcnt();
        for (int k = 0; k < 4; k++) pcnt[k] = 0;
    endtask

    initial begin
        bit found;
        reset_n = 1'b1; cfg_we = 0; cfg_ch = 0; cfg_period = 0;
        cfg_mode = 0; cfg_start = 0; enable = 4'hF; cfg_we3 = 0;
        #1 reset_n = 1'b0;
        #20;
        check("rst_pulse", 32'(pulse), 32'h0);
        check("rst_running", 32'(running), 32'hF);
        check("rst_done", 32'(done), 32'h0);
        check("rst_running_n3", 32'(running3), 32'h7);
        @(posedge clk); #1 reset_n = 1'b1;
        model_reset();

        idle(305);
        check("default_pulses_ch0", 32'(pcnt[0]), 32'd3);
        check("default_pulses_ch3", 32'(pcnt[3]), 32'd3);

        step(1, 2, 5, 1, 1, 4'hF);
        clr_pcnt();
        idle(8);
        check("oneshot_count", 32'(pcnt[2]), 32'd1);
        check("oneshot_done", 32'(done[2]), 32'd1);
        check("oneshot_stopped", 32'(running[2]), 32'd0);
        step(1, 2, 5, 1, 0, 4'hF);
        check("done_cleared", 32'(done[2]), 32'd0);

        step(1, 1, 4, 0, 1, 4'hF);
        clr_pcnt();
        foreach (pcnt[i]) begin end
        begin
            bit pat[7] = '{1, 0, 1, 1, 0, 1, 1};
            for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, {2'b11, pat[i], 1'b1});
        end
        step(0, 0, 0, 0, 0, 4'b1101);
        check("gated_count", 32'(pcnt[1]), 32'd1);

        step(1, 0, 3, 0, 1, 4'hF);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (m_rem[0] == 1) found = 1;
            else step(0, 0, 0, 0, 0, 4'hF);
        end
        check("tc_found", 32'(found), 32'd1);
        step(1, 0, 3, 0, 1, 4'hF);
        check("tc_write_no_pulse", 32'(pulse[0]), 32'd0);
        idle(6);

        step(1, 1, 0, 0, 1, 4'hF);
        clr_pcnt();
        idle(10);
        check("period0_none", 32'(pcnt[1]), 32'd0);
        check("period0_running", 32'(running[1]), 32'd1);
        step(1, 1, 1, 0, 1, 4'hF);
        clr_pcnt();
        idle(10);
        check("period1_every", 32'(pcnt[1]), 32'd9);

        for (int i = 0; i < 1500; i++)
            step(($urandom % 8) == 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
                 1'($urandom), ($urandom % 4) != 0, 4'($urandom | $urandom));

        step(1, 3, 1, 1, 1, 4'hF);
        idle(1);
        check("inflight_pulse", 32'(pulse[3]), 32'd1);
        check("inflight_done", 32'(done[3]), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_pulse", 32'(pulse), 32'h0);
        check("async_done", 32'(done), 32'h0);
        check("async_running", 32'(running), 32'hF);
        check("async_pulse_n3", 32'(pulse3), 32'h0);
        @(posedge clk); #1 reset_n = 1'b1;
        model_reset();
        idle(102);
        check("post_rst_ch0", 32'(pcnt[0]), 32'd1);
        check("post_rst_ch3", 32'(pcnt[3]), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
